// File: rtl/c_top.sv
`default_nettype none
// ============================================================================
// c_top : RV32I main control + ALU-control decoder, registered outputs
// Revision: 1.0
// ============================================================================
module c_top #(
  parameter int oplen = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [oplen-1:0] op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             branch,
  output logic             memtoreg,
  output logic [3:0]       ALUOp_control
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic       upper_zero;
  logic [6:0] op_low;

  // Any set bit above the 7-bit opcode makes the instruction unrecognized.
  generate
    if (oplen > 7) begin : g_wide_op
      assign upper_zero = ~|op[oplen-1:7];
    end else begin : g_narrow_op
      assign upper_zero = 1'b1;
    end
  endgenerate

  assign op_low = op[6:0];

  logic       reg_write_d;
  logic       alu_src_d;
  logic [1:0] alu_op_d;
  logic       mem_read_d;
  logic       mem_write_d;
  logic       branch_d;
  logic       memtoreg_d;
  logic [3:0] alu_ctrl_d;

  always_comb begin
    reg_write_d = 1'b0;
    alu_src_d   = 1'b0;
    alu_op_d    = 2'b00;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    memtoreg_d  = 1'b0;
    if (upper_zero) begin
      case (op_low)
        OP_RTYPE: begin
          reg_write_d = 1'b1;
          alu_op_d    = 2'b10;
        end
        OP_LOAD: begin
          reg_write_d = 1'b1;
          alu_src_d   = 1'b1;
          mem_read_d  = 1'b1;
          memtoreg_d  = 1'b1;
        end
        OP_STORE: begin
          alu_src_d   = 1'b1;
          mem_write_d = 1'b1;
        end
        OP_BRANCH: begin
          alu_op_d = 2'b01;
          branch_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_ctrl_d = 4'b0010;
    case (alu_op_d)
      2'b01: alu_ctrl_d = 4'b0110;
      2'b10: begin
        case (funct3)
          3'b000: alu_ctrl_d = funct7[5] ? 4'b0110 : 4'b0010;
          3'b001: alu_ctrl_d = 4'b0011;
          3'b010: alu_ctrl_d = 4'b1000;
          3'b011: alu_ctrl_d = 4'b1001;
          3'b100: alu_ctrl_d = 4'b0100;
          3'b101: alu_ctrl_d = funct7[5] ? 4'b0111 : 4'b0101;
          3'b110: alu_ctrl_d = 4'b0001;
          default: alu_ctrl_d = 4'b0000;
        endcase
      end
      default: alu_ctrl_d = 4'b0010;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite      <= 1'b0;
      ALUSrc        <= 1'b0;
      ALUOp         <= 2'b00;
      MemRead       <= 1'b0;
      MemWrite      <= 1'b0;
      branch        <= 1'b0;
      memtoreg      <= 1'b0;
      ALUOp_control <= 4'b0000;
    end else begin
      RegWrite      <= reg_write_d;
      ALUSrc        <= alu_src_d;
      ALUOp         <= alu_op_d;
      MemRead       <= mem_read_d;
      MemWrite      <= mem_write_d;
      branch        <= branch_d;
      memtoreg      <= memtoreg_d;
      ALUOp_control <= alu_ctrl_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c_top.sv
`default_nettype none
// ============================================================================
// tb_c_top : directed self-checking bench for c_top
// Revision: 1.0
// ============================================================================
module tb_c_top;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       RegWrite, ALUSrc, MemRead, MemWrite, branch, memtoreg;
  logic [1:0] ALUOp;
  logic [3:0] ALUOp_control;

  int compared   = 0;
  int mismatched = 0;

  c_top #(.oplen(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7        (funct7),
    .RegWrite      (RegWrite),
    .ALUSrc        (ALUSrc),
    .ALUOp         (ALUOp),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .branch        (branch),
    .memtoreg      (memtoreg),
    .ALUOp_control (ALUOp_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {RegWrite, ALUSrc, ALUOp, MemRead, MemWrite, branch, memtoreg, ALUOp_control}
  logic [11:0] obs;
  assign obs = {RegWrite, ALUSrc, ALUOp, MemRead, MemWrite, branch, memtoreg, ALUOp_control};

  localparam logic [7:0] R_STROBES = 8'b1_0_10_0_0_0_0;

  task automatic check(input string tag, input logic [11:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    op = o; funct3 = f3; funct7 = f7;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 12'b0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", {R_STROBES, 4'b0010});

    step(7'b0110011, 3'b000, 7'b0000000); check("r_add",  {R_STROBES, 4'b0010});
    step(7'b0110011, 3'b000, 7'b0100000); check("r_sub",  {R_STROBES, 4'b0110});
    step(7'b0110011, 3'b001, 7'b0000000); check("r_sll",  {R_STROBES, 4'b0011});
    step(7'b0110011, 3'b111, 7'b0000000); check("r_and",  {R_STROBES, 4'b0000});
    step(7'b0110011, 3'b010, 7'b0000000); check("r_slt",  {R_STROBES, 4'b1000});
    step(7'b0110011, 3'b011, 7'b0000000); check("r_sltu", {R_STROBES, 4'b1001});
    step(7'b0110011, 3'b100, 7'b0000000); check("r_xor",  {R_STROBES, 4'b0100});
    step(7'b0110011, 3'b110, 7'b0000000); check("r_or",   {R_STROBES, 4'b0001});
    step(7'b0110011, 3'b101, 7'b0000000); check("r_srl",  {R_STROBES, 4'b0101});
    step(7'b0110011, 3'b101, 7'b0100000); check("r_sra",  {R_STROBES, 4'b0111});
    // Only funct7[5] selects the alternate op; other bits are ignored.
    step(7'b0110011, 3'b101, 7'b1011111); check("r_srl_f7junk", {R_STROBES, 4'b0101});

    step(7'b0000011, 3'b101, 7'b0100000); check("load",   12'b1_1_00_1_0_0_1_0010);
    step(7'b0100011, 3'b001, 7'b0000000); check("store",  12'b0_1_00_0_1_0_0_0010);
    step(7'b1100011, 3'b111, 7'b0000000); check("branch", 12'b0_0_01_0_0_1_0_0110);

    // Inputs changing between edges must not disturb held outputs.
    #2;
    op = 7'b0110011; funct3 = 3'b111;
    #1;
    check("hold_between_edges", 12'b0_0_01_0_0_1_0_0110);

    step(7'b1111111, 3'b000, 7'b0100000); check("unknown_op", 12'b0_0_00_0_0_0_0_0010);

    step(7'b0000011, 3'b000, 7'b0000000); check("load_again", 12'b1_1_00_1_0_0_1_0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_midcycle", 12'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 12'b0);

    @(negedge clk);
    rst_n = 1'b1;
    op = 7'b0100011;
    @(posedge clk);
    #1;
    check("store_after_rerelease", 12'b0_1_00_0_1_0_0_0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
